// File: rtl/vshifter_pipe.sv
// Two-stage per-element vector shifter (SLL/SRL/SRA/pass) with valid/ready handshakes.
// Define VSHIFTER_MASK_EN to add in_mask/in_old per-element merge with the prior destination.
module vshifter_pipe #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_ELEM8  = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_src,
    input  logic [DATA_WIDTH-1:0] in_shamt,
    input  logic [1:0]            in_sew,
    input  logic [1:0]            in_op,
`ifdef VSHIFTER_MASK_EN
    input  logic [NUM_ELEM8-1:0]  in_mask,
    input  logic [DATA_WIDTH-1:0] in_old,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result
);

    localparam int NUM_ELEM16 = DATA_WIDTH / 16;
    localparam int NUM_ELEM32 = DATA_WIDTH / 32;
    localparam int NUM_ELEM64 = DATA_WIDTH / 64;

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRL  = 2'b01,
        OP_SRA  = 2'b10,
        OP_PASS = 2'b11
    } op_e;

    // Element is zero-extended into 64 bits; lane_mask marks its real bits so
    // SRA can sign-fill above them before shifting. Caller keeps the low bits.
    function automatic logic [63:0] shift_elem(
        input logic [63:0] v,
        input logic [63:0] a,
        input logic [63:0] lane_mask,
        input logic [63:0] amt_mask,
        input op_e         op,
        input logic        sign
    );
        logic [63:0] ext;
        logic [63:0] amt;
        amt = a & amt_mask;
        ext = (op == OP_SRA && sign) ? (v | ~lane_mask) : v;
        unique case (op)
            OP_SLL:  return ext << amt;
            OP_SRL:  return ext >> amt;
            OP_SRA:  return 64'($signed(ext) >>> amt);
            default: return v;
        endcase
    endfunction

    logic                  rst_sync;
    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_src;
    logic [DATA_WIDTH-1:0] s1_shamt;
    logic [1:0]            s1_sew;
    op_e                   s1_op;
    logic                  s2_valid;
    logic [DATA_WIDTH-1:0] s2_result;
    logic                  s2_en;
    logic                  accept;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] result;
    logic [63:0]           tmp;
`ifdef VSHIFTER_MASK_EN
    logic [NUM_ELEM8-1:0]  s1_mask;
    logic [DATA_WIDTH-1:0] s1_old;
    logic [NUM_ELEM8-1:0]  byte_en;
`endif

    // rst_sync rises on the first edge after release, so no transfer can land on that edge.
    assign s2_en    = !s2_valid || out_ready;
    assign in_ready = !rst_n || (rst_sync && (!s1_valid || s2_en));
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            rst_sync <= 1'b0;
            s1_valid <= 1'b0;
        end else begin
            rst_sync <= 1'b1;
            if (in_ready) s1_valid <= in_valid;
        end
    end

    // NOTE: operand registers carry no reset; s1_valid alone says whether they mean anything.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_src   <= in_src;
            s1_shamt <= in_shamt;
            s1_sew   <= in_sew;
            s1_op    <= op_e'(in_op);
`ifdef VSHIFTER_MASK_EN
            s1_mask  <= in_mask;
            s1_old   <= in_old;
`endif
        end
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        shifted = '0;
        tmp     = '0;
        unique case (s1_sew)
            2'b00: for (int i = 0; i < NUM_ELEM8; i++) begin
                tmp = shift_elem(64'(s1_src[i*8 +: 8]), 64'(s1_shamt[i*8 +: 8]),
                                 64'h0000_0000_0000_00FF, 64'd7, s1_op, s1_src[i*8+7]);
                shifted[i*8 +: 8] = tmp[7:0];
            end
            2'b01: for (int i = 0; i < NUM_ELEM16; i++) begin
                tmp = shift_elem(64'(s1_src[i*16 +: 16]), 64'(s1_shamt[i*16 +: 16]),
                                 64'h0000_0000_0000_FFFF, 64'd15, s1_op, s1_src[i*16+15]);
                shifted[i*16 +: 16] = tmp[15:0];
            end
            2'b10: for (int i = 0; i < NUM_ELEM32; i++) begin
                tmp = shift_elem(64'(s1_src[i*32 +: 32]), 64'(s1_shamt[i*32 +: 32]),
                                 64'h0000_0000_FFFF_FFFF, 64'd31, s1_op, s1_src[i*32+31]);
                shifted[i*32 +: 32] = tmp[31:0];
            end
            default: for (int i = 0; i < NUM_ELEM64; i++) begin
                tmp = shift_elem(s1_src[i*64 +: 64], s1_shamt[i*64 +: 64],
                                 64'hFFFF_FFFF_FFFF_FFFF, 64'd63, s1_op, s1_src[i*64+63]);
                shifted[i*64 +: 64] = tmp;
            end
        endcase
    end

`ifdef VSHIFTER_MASK_EN
    // Expand the per-element mask to bytes; mask bits past the element count never get read.
    always_comb begin
        byte_en = '0;
        result  = '0;
        for (int b = 0; b < NUM_ELEM8; b++) begin
            unique case (s1_sew)
                2'b00:   byte_en[b] = s1_mask[b];
                2'b01:   byte_en[b] = s1_mask[b/2];
                2'b10:   byte_en[b] = s1_mask[b/4];
                default: byte_en[b] = s1_mask[b/8];
            endcase
            result[b*8 +: 8] = byte_en[b] ? shifted[b*8 +: 8] : s1_old[b*8 +: 8];
        end
    end
`else
    assign result = shifted;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
        end else if (s2_en) begin
            s2_valid <= s1_valid;
            if (s1_valid) s2_result <= result;
        end
    end

    assign out_valid  = s2_valid;
    assign out_result = s2_result;

endmodule

// File: tb/tb_vshifter_pipe.sv
// Scoreboard bench for vshifter_pipe (DATA_WIDTH=64): driver queues expected results, monitor checks them.
module tb_vshifter_pipe;

    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_src;
    logic [DW-1:0] in_shamt;
    logic [1:0]    in_sew;
    logic [1:0]    in_op;
    logic [7:0]    in_mask;
    logic [DW-1:0] in_old;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_result;

    typedef struct {
        logic [63:0] src;
        logic [63:0] shamt;
        logic [1:0]  sew;
        logic [1:0]  op;
        logic [7:0]  mask;
        logic [63:0] old;
        logic [63:0] exp;
    } vec_t;

    logic [63:0] exp_q[$];
    vec_t        vecs[10];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    bit          prev_stall = 1'b0;
    logic [63:0] prev_res;

    vshifter_pipe #(.DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_src    (in_src),
        .in_shamt  (in_shamt),
        .in_sew    (in_sew),
        .in_op     (in_op),
`ifdef VSHIFTER_MASK_EN
        .in_mask   (in_mask),
        .in_old    (in_old),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] sew, input logic [1:0] op,
                                input logic [63:0] src, input logic [63:0] shamt,
                                input logic [63:0] exp);
        vec_t v;
        v.src = src; v.shamt = shamt; v.sew = sew; v.op = op;
        v.mask = 8'hFF; v.old = '0; v.exp = exp;
        return v;
    endfunction

    // Called just after a rising edge; returns just after the edge that took the request.
    task automatic send(input vec_t v);
        in_valid = 1'b1;
        in_src   = v.src;
        in_shamt = v.shamt;
        in_sew   = v.sew;
        in_op    = v.op;
        in_mask  = v.mask;
        in_old   = v.old;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(v.exp);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        check("send_timeout", 65'd1, 65'd0);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        check("drain", 65'(exp_q.size()), 65'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) check("hold", {out_valid, out_result}, {1'b1, prev_res});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("spurious_result", {1'b1, out_result}, 65'd0);
                else check("result", {1'b0, out_result}, {1'b0, exp_q.pop_front()});
            end
            prev_stall = out_valid && !out_ready;
            prev_res   = out_result;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        int t0;
        vec_t mv;
        vecs[0] = mk(2'b00, 2'b10, 64'h8080808080808080, 64'h0A0A0A0A0A0A0A0A, 64'hE0E0E0E0E0E0E0E0);
        vecs[1] = mk(2'b11, 2'b00, 64'h1, 64'd63, 64'h8000000000000000);
        vecs[2] = mk(2'b11, 2'b00, 64'h1, 64'd64, 64'h1);
        vecs[3] = mk(2'b01, 2'b01, 64'hFFFF_8000_0001_1234, 64'h0004_0004_0004_0004, 64'h0FFF_0800_0000_0123);
        vecs[4] = mk(2'b11, 2'b11, 64'h0123456789ABCDEF, 64'h5, 64'h0123456789ABCDEF);
        vecs[5] = mk(2'b10, 2'b10, 64'h80000000_7FFFFFFF, 64'h00000021_0000001F, 64'hC0000000_00000000);
        vecs[6] = mk(2'b00, 2'b00, 64'hFFFFFFFFFFFFFFFF, 64'h0706050403020100, 64'h80C0E0F0F8FCFEFF);
        vecs[7] = mk(2'b01, 2'b10, 64'h7FFF_8001_0000_FFFF, 64'h000F_0001_0003_0010, 64'h0000_C000_0000_FFFF);
        vecs[8] = mk(2'b11, 2'b01, 64'h8000000000000000, 64'h44, 64'h0800000000000000);
        vecs[9] = mk(2'b11, 2'b10, 64'h8000000000000000, 64'd63, 64'hFFFFFFFFFFFFFFFF);

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_src = '0; in_shamt = '0; in_sew = '0; in_op = '0; in_mask = '1; in_old = '0;
        #1;
        check("reset_in_ready", 65'(in_ready), 65'd1);
        check("reset_out_valid", 65'(out_valid), 65'd0);
        check("reset_out_result", 65'(out_result), 65'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;

        // Exact two-cycle latency on an empty pipe.
        send(vecs[0]);
        @(negedge clk) check("latency_not_early", 65'(out_valid), 65'd0);
        @(negedge clk) check("latency_two_cycles", 65'(out_valid), 65'd1);
        drain();

        // Back-to-back with out_ready held: one accept per cycle.
        @(posedge clk); #1;
        t0 = cyc;
        for (int i = 1; i < 10; i++) send(vecs[i]);
        check("throughput_cycles", 65'(cyc - t0), 65'd9);
        drain();

`ifdef VSHIFTER_MASK_EN
        mv = mk(2'b10, 2'b00, 64'h00000001_00000001, 64'h00000001_00000001, 64'hAAAAAAAA_00000002);
        mv.mask = 8'h01;
        mv.old  = 64'hAAAAAAAA_BBBBBBBB;
        @(posedge clk); #1;
        send(mv);
        drain();
`endif

        // Backpressure: four requests, output stalled for six cycles.
        @(posedge clk); #1;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) send(vecs[i]);
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                check("stall_in_ready_low", 65'(in_ready), 65'd0);
                check("stall_accepted_two", 65'(exp_q.size()), 65'd2);
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two transactions in flight.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(vecs[5]);
        send(vecs[6]);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_out_valid", 65'(out_valid), 65'd0);
        check("midreset_out_result", 65'(out_result), 65'd0);
        check("midreset_in_ready", 65'(in_ready), 65'd1);
        exp_q.delete();
        @(negedge clk) rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("no_stale_after_reset", 65'(out_valid), 65'd0);
        @(posedge clk); #1;
        send(vecs[7]);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
